// File: rtl/lock_seq_ctrl.sv
// -----------------------------------------------------------------------------
// lock_seq_ctrl
//   Sequencing controller for the switch-based combination lock. It takes
//   debounced, edge-detected strobes and compares an N-digit code against a
//   stored password. It counts consecutive failed attempts and enforces a
//   timed lockout, which it counts down in BCD for the 7-segment scanner. It
//   also reprograms the password while the lock is open.
//
//   Strobe semantics: every *_stb input and tick is a single-cycle pulse that
//   is consumed at the posedge where it is high. There is no back-pressure.
//   A strobe that the current state does not use is simply dropped.
//
// Ports
//   clk         in   1       system clock, all logic on posedge
//   rst_n       in   1       synchronous reset, active-low
//   digit_stb   in   1       take code_in as the next digit
//   submit_stb  in   1       end entry and evaluate it
//   prog_stb    in   1       start password reprogramming (UNLOCKED only)
//   logout_stb  in   1       relock, or abort programming
//   tick        in   1       time-base pulse used by the lockout countdown
//   code_in     in   CODE_W  digit value from the switches
//   state       out  3       IDLE=0 ENTRY=1 UNLOCKED=2 PROG=3 LOCKOUT=4
//   unlocked    out  1       high in UNLOCKED or PROG
//   err_cnt     out  2       consecutive failures since last success/lockout
//   digit_cnt   out  2       digits taken in the current entry/program
//   cd_bcd      out  12      lockout remaining {hund,tens,ones}; 0 otherwise
//   ok_pulse    out  1       one-cycle pulse on a successful submit
//   fail_pulse  out  1       one-cycle pulse on a failed submit
// -----------------------------------------------------------------------------
module lock_seq_ctrl #(
  parameter int          CODE_W   = 7,
  parameter int          N_DIGITS = 3,
  parameter int          MAX_ERR  = 3,
  parameter logic [11:0] LOCK_BCD = 12'h600
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              digit_stb,
  input  logic              submit_stb,
  input  logic              prog_stb,
  input  logic              logout_stb,
  input  logic              tick,
  input  logic [CODE_W-1:0] code_in,
  output logic [2:0]        state,
  output logic              unlocked,
  output logic [1:0]        err_cnt,
  output logic [1:0]        digit_cnt,
  output logic [11:0]       cd_bcd,
  output logic              ok_pulse,
  output logic              fail_pulse
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ENTRY    = 3'd1,
    S_UNLOCKED = 3'd2,
    S_PROG     = 3'd3,
    S_LOCKOUT  = 3'd4
  } state_e;

  localparam logic [1:0] N_DIG_C    = 2'(N_DIGITS);
  localparam logic [1:0] LAST_DIGIT = 2'(N_DIGITS - 1);
  localparam logic [2:0] MAX_ERR_C  = 3'(MAX_ERR);

  state_e            state_q, state_d;
  logic [CODE_W-1:0] pwd_q    [N_DIGITS];
  logic [CODE_W-1:0] pwd_d    [N_DIGITS];
  logic [CODE_W-1:0] shadow_q [N_DIGITS];
  logic [CODE_W-1:0] shadow_d [N_DIGITS];
  logic [1:0]        err_q, err_d;
  logic [1:0]        dcnt_q, dcnt_d;
  logic              match_q, match_d;
  logic [11:0]       cd_q, cd_d;
  logic              unl_q, unl_d;
  logic              ok_q, ok_d;
  logic              fail_q, fail_d;

  // Three-digit BCD decrement with borrow. Never called with 0x000 because
  // the countdown leaves LOCKOUT on the tick that would reach zero.
  function automatic logic [11:0] bcd_dec(input logic [11:0] v);
    logic [3:0] ones;
    logic [3:0] tens;
    logic [3:0] hund;
    logic       b_ones;
    logic       b_tens;
    ones   = v[3:0];
    tens   = v[7:4];
    hund   = v[11:8];
    b_ones = (ones == 4'd0);
    b_tens = b_ones && (tens == 4'd0);
    ones   = b_ones ? 4'd9 : ones - 4'd1;
    if (b_ones) begin
      tens = (tens == 4'd0) ? 4'd9 : tens - 4'd1;
    end
    if (b_tens) begin
      hund = hund - 4'd1;
    end
    return {hund, tens, ones};
  endfunction

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    pwd_d    = pwd_q;
    shadow_d = shadow_q;
    err_d    = err_q;
    dcnt_d   = dcnt_q;
    match_d  = match_q;
    cd_d     = cd_q;
    ok_d     = 1'b0;
    fail_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // The first digit both opens the entry and is compared as digit 0.
        if (digit_stb) begin
          state_d = S_ENTRY;
          match_d = match_q && (code_in == pwd_q[0]);
          dcnt_d  = 2'd1;
        end
      end

      S_ENTRY: begin
        // Submit has priority; a digit arriving in the same cycle is lost.
        if (submit_stb) begin
          dcnt_d  = 2'd0;
          match_d = 1'b1;
          if (match_q && (dcnt_q == N_DIG_C)) begin
            state_d = S_UNLOCKED;
            err_d   = 2'd0;
            ok_d    = 1'b1;
          end else begin
            fail_d = 1'b1;
            // Widened compare so err_cnt+1 never wraps.
            if (({1'b0, err_q} + 3'd1) == MAX_ERR_C) begin
              state_d = S_LOCKOUT;
              err_d   = 2'd0;
              cd_d    = LOCK_BCD;
            end else begin
              state_d = S_IDLE;
              err_d   = err_q + 2'd1;
            end
          end
        end else if (digit_stb) begin
          if (dcnt_q < N_DIG_C) begin
            match_d = match_q && (code_in == pwd_q[dcnt_q]);
            dcnt_d  = dcnt_q + 2'd1;
          end else begin
            // Overlong entry: poison the attempt, counter stays at N_DIGITS.
            match_d = 1'b0;
          end
        end
      end

      S_UNLOCKED: begin
        if (logout_stb) begin
          state_d = S_IDLE;
        end else if (prog_stb) begin
          state_d = S_PROG;
          dcnt_d  = 2'd0;
        end
      end

      S_PROG: begin
        if (logout_stb) begin
          // Abort: the live password is untouched, staged digits are dropped.
          state_d = S_IDLE;
          dcnt_d  = 2'd0;
        end else if (digit_stb) begin
          shadow_d[dcnt_q] = code_in;
          if (dcnt_q == LAST_DIGIT) begin
            // Commit the staged digits plus this one in a single edge so the
            // password is never half-updated.
            pwd_d   = shadow_d;
            state_d = S_UNLOCKED;
            dcnt_d  = 2'd0;
          end else begin
            dcnt_d = dcnt_q + 2'd1;
          end
        end
      end

      S_LOCKOUT: begin
        if (tick) begin
          if (cd_q == 12'h001) begin
            cd_d    = 12'h000;
            state_d = S_IDLE;
          end else begin
            cd_d = bcd_dec(cd_q);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        dcnt_d  = 2'd0;
        match_d = 1'b1;
        cd_d    = 12'h000;
      end
    endcase

    // Registered from the next state so it lines up with the state output.
    unl_d = (state_d == S_UNLOCKED) || (state_d == S_PROG);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      for (int i = 0; i < N_DIGITS; i++) begin
        pwd_q[i]    <= '0;
        shadow_q[i] <= '0;
      end
      err_q   <= 2'd0;
      dcnt_q  <= 2'd0;
      match_q <= 1'b1;
      cd_q    <= 12'h000;
      unl_q   <= 1'b0;
      ok_q    <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pwd_q    <= pwd_d;
      shadow_q <= shadow_d;
      err_q    <= err_d;
      dcnt_q   <= dcnt_d;
      match_q  <= match_d;
      cd_q     <= cd_d;
      unl_q    <= unl_d;
      ok_q     <= ok_d;
      fail_q   <= fail_d;
    end
  end

  assign state      = state_q;
  assign unlocked   = unl_q;
  assign err_cnt    = err_q;
  assign digit_cnt  = dcnt_q;
  assign cd_bcd     = cd_q;
  assign ok_pulse   = ok_q;
  assign fail_pulse = fail_q;

endmodule

// File: tb/tb_lock_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lock_seq_ctrl
//   Directed bench for lock_seq_ctrl. A behavioural model tracks the lock in
//   terms of entered-digit lists and a remaining-tick integer; after each
//   posedge it pushes the full expected output vector onto exp_q and the
//   negedge compare process checks the DUT against it. Hand-computed literal
//   checks in the main sequence pin the model itself.
// -----------------------------------------------------------------------------
module tb_lock_seq_ctrl;

  localparam int N_DIGITS   = 3;
  localparam int MAX_ERR    = 3;
  localparam int LOCK_TICKS = 600;

  localparam int ST_IDLE  = 0;
  localparam int ST_ENTRY = 1;
  localparam int ST_UNL   = 2;
  localparam int ST_PROG  = 3;
  localparam int ST_LOCK  = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk        = 1'b0;
  logic        rst_n      = 1'b0;
  logic        digit_stb  = 1'b0;
  logic        submit_stb = 1'b0;
  logic        prog_stb   = 1'b0;
  logic        logout_stb = 1'b0;
  logic        tick       = 1'b0;
  logic [6:0]  code_in    = 7'h00;
  logic [2:0]  state;
  logic        unlocked;
  logic [1:0]  err_cnt;
  logic [1:0]  digit_cnt;
  logic [11:0] cd_bcd;
  logic        ok_pulse;
  logic        fail_pulse;

  always #5 clk = ~clk;

  lock_seq_ctrl #(
    .CODE_W   (7),
    .N_DIGITS (N_DIGITS),
    .MAX_ERR  (MAX_ERR),
    .LOCK_BCD (12'h600)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .digit_stb  (digit_stb),
    .submit_stb (submit_stb),
    .prog_stb   (prog_stb),
    .logout_stb (logout_stb),
    .tick       (tick),
    .code_in    (code_in),
    .state      (state),
    .unlocked   (unlocked),
    .err_cnt    (err_cnt),
    .digit_cnt  (digit_cnt),
    .cd_bcd     (cd_bcd),
    .ok_pulse   (ok_pulse),
    .fail_pulse (fail_pulse)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int          checks   = 0;
  int          failures = 0;
  logic [21:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  int         m_state = ST_IDLE;
  int         m_err   = 0;
  int         m_ticks = 0;
  bit         m_ok    = 1'b0;
  bit         m_fail  = 1'b0;
  logic [6:0] m_pwd[N_DIGITS];
  logic [6:0] m_entry[$];
  logic [6:0] m_prog[$];

  function automatic logic [11:0] to_bcd(input int n);
    return 12'((n / 100) * 256 + ((n / 10) % 10) * 16 + (n % 10));
  endfunction

  task automatic model_step(input bit d, input bit s, input bit p, input bit l,
                            input bit t, input logic [6:0] c);
    bit          pass;
    int          dc;
    logic [11:0] bcd;
    m_ok   = 1'b0;
    m_fail = 1'b0;
    if (!rst_n) begin
      m_state = ST_IDLE;
      m_err   = 0;
      m_ticks = 0;
      for (int i = 0; i < N_DIGITS; i++) m_pwd[i] = 7'h00;
      m_entry.delete();
      m_prog.delete();
    end else begin
      case (m_state)
        ST_IDLE: begin
          if (d) begin
            m_entry.delete();
            m_entry.push_back(c);
            m_state = ST_ENTRY;
          end
        end
        ST_ENTRY: begin
          if (s) begin
            pass = (m_entry.size() == N_DIGITS);
            if (pass) begin
              for (int i = 0; i < N_DIGITS; i++) if (m_entry[i] != m_pwd[i]) pass = 1'b0;
            end
            m_entry.delete();
            if (pass) begin
              m_state = ST_UNL;
              m_err   = 0;
              m_ok    = 1'b1;
            end else begin
              m_fail = 1'b1;
              m_err  = m_err + 1;
              if (m_err >= MAX_ERR) begin
                m_err   = 0;
                m_ticks = LOCK_TICKS;
                m_state = ST_LOCK;
              end else begin
                m_state = ST_IDLE;
              end
            end
          end else if (d) begin
            m_entry.push_back(c);
          end
        end
        ST_UNL: begin
          if (l) begin
            m_state = ST_IDLE;
          end else if (p) begin
            m_prog.delete();
            m_state = ST_PROG;
          end
        end
        ST_PROG: begin
          if (l) begin
            m_prog.delete();
            m_state = ST_IDLE;
          end else if (d) begin
            m_prog.push_back(c);
            if (m_prog.size() == N_DIGITS) begin
              for (int i = 0; i < N_DIGITS; i++) m_pwd[i] = m_prog[i];
              m_prog.delete();
              m_state = ST_UNL;
            end
          end
        end
        default: begin
          if (t) begin
            m_ticks = m_ticks - 1;
            if (m_ticks == 0) m_state = ST_IDLE;
          end
        end
      endcase
    end

    if (m_state == ST_ENTRY)     dc = (m_entry.size() < N_DIGITS) ? m_entry.size() : N_DIGITS;
    else if (m_state == ST_PROG) dc = m_prog.size();
    else                         dc = 0;
    bcd = (m_state == ST_LOCK) ? to_bcd(m_ticks) : 12'h000;
    exp_q.push_back({3'(m_state), ((m_state == ST_UNL) || (m_state == ST_PROG)),
                     2'(m_err), 2'(dc), bcd, m_ok, m_fail});
  endtask

  // ---------------------------------------------------------------------------
  // Compare process: every cycle the model produced an expectation
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    logic [21:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("state",      32'(state),      32'(e[21:19]));
      chk("unlocked",   32'(unlocked),   32'(e[18]));
      chk("err_cnt",    32'(err_cnt),    32'(e[17:16]));
      chk("digit_cnt",  32'(digit_cnt),  32'(e[15:14]));
      chk("cd_bcd",     32'(cd_bcd),     32'(e[13:2]));
      chk("ok_pulse",   32'(ok_pulse),   32'(e[1]));
      chk("fail_pulse", 32'(fail_pulse), 32'(e[0]));
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (called at a negedge, return at the following negedge)
  // ---------------------------------------------------------------------------
  task automatic cyc(input bit d, input bit s, input bit p, input bit l,
                     input bit t, input logic [6:0] c);
    digit_stb  = d;
    submit_stb = s;
    prog_stb   = p;
    logout_stb = l;
    tick       = t;
    code_in    = c;
    @(posedge clk);
    model_step(d, s, p, l, t, c);
    @(negedge clk);
  endtask

  task automatic idle();                 cyc(0, 0, 0, 0, 0, 7'h00); endtask
  task automatic dig(input logic [6:0] c); cyc(1, 0, 0, 0, 0, c);   endtask
  task automatic sub();                  cyc(0, 1, 0, 0, 0, 7'h00); endtask
  task automatic prg();                  cyc(0, 0, 1, 0, 0, 7'h00); endtask
  task automatic lgo();                  cyc(0, 0, 0, 1, 0, 7'h00); endtask
  task automatic tck();                  cyc(0, 0, 0, 0, 1, 7'h00); endtask

  task automatic enter3(input logic [6:0] a, input logic [6:0] b, input logic [6:0] c);
    dig(a);
    dig(b);
    dig(c);
    sub();
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    @(negedge clk);
    rst_n = 1'b0;
    idle();
    idle();
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_cd",    32'(cd_bcd), 32'h0);
    rst_n = 1'b1;
    idle();

    // IDLE ignores everything except digits.
    cyc(0, 1, 1, 1, 1, 7'h00);
    chk("idle_ignore", 32'(state), 32'd0);

    // T1: default password is all zeros.
    enter3(7'h00, 7'h00, 7'h00);
    chk("t1_ok",       32'(ok_pulse), 32'd1);
    chk("t1_state",    32'(state),    32'd2);
    chk("t1_unlocked", 32'(unlocked), 32'd1);
    lgo();

    // T2: three wrong attempts -> lockout, then 600 ticks.
    enter3(7'h01, 7'h01, 7'h01);
    chk("t2_fail1", 32'(fail_pulse), 32'd1);
    chk("t2_err1",  32'(err_cnt),    32'd1);
    enter3(7'h01, 7'h01, 7'h01);
    chk("t2_err2",  32'(err_cnt),    32'd2);
    enter3(7'h01, 7'h01, 7'h01);
    chk("t2_lock",  32'(state),      32'd4);
    chk("t2_cd600", 32'(cd_bcd),     32'h600);
    chk("t2_err0",  32'(err_cnt),    32'd0);
    for (int i = 0; i < LOCK_TICKS - 1; i++) begin
      cyc((i % 4) == 1, (i % 4) == 2, (i % 4) == 3, (i % 5) == 4, 1'b1, 7'h00);
      if (i == 499) chk("t2_cd100", 32'(cd_bcd), 32'h100);
      if (i == 500) chk("t2_cd099", 32'(cd_bcd), 32'h099);
    end
    cyc(1, 1, 1, 1, 0, 7'h00);
    chk("t2_cd001", 32'(cd_bcd), 32'h001);
    tck();
    chk("t2_exit",  32'(state),  32'd0);
    chk("t2_cd0",   32'(cd_bcd), 32'h000);

    // T3: reprogram to 15,2A,7F.
    enter3(7'h00, 7'h00, 7'h00);
    prg();
    cyc(0, 1, 1, 0, 0, 7'h00);
    dig(7'h15);
    dig(7'h2A);
    dig(7'h7F);
    chk("t3_commit", 32'(state), 32'd2);
    lgo();
    enter3(7'h00, 7'h00, 7'h00);
    chk("t3_old_fails", 32'(fail_pulse), 32'd1);
    enter3(7'h15, 7'h2A, 7'h7F);
    chk("t3_new_ok",  32'(ok_pulse), 32'd1);
    chk("t3_err_clr", 32'(err_cnt),  32'd0);
    lgo();

    // T4: too short and too long entries both fail.
    dig(7'h15);
    dig(7'h2A);
    sub();
    chk("t4_short_fail", 32'(fail_pulse), 32'd1);
    chk("t4_short_err",  32'(err_cnt),    32'd1);
    chk("t4_short_st",   32'(state),      32'd0);
    dig(7'h15);
    dig(7'h2A);
    dig(7'h7F);
    dig(7'h15);
    chk("t4_dcnt_hold", 32'(digit_cnt), 32'd3);
    sub();
    chk("t4_long_fail", 32'(fail_pulse), 32'd1);
    chk("t4_long_err",  32'(err_cnt),    32'd2);
    enter3(7'h15, 7'h2A, 7'h7F);
    chk("t4_recover", 32'(err_cnt), 32'd0);

    // T5: aborted programming keeps the old password.
    prg();
    dig(7'h01);
    dig(7'h02);
    chk("t5_prog_cnt", 32'(digit_cnt), 32'd2);
    lgo();
    chk("t5_abort", 32'(state), 32'd0);
    enter3(7'h15, 7'h2A, 7'h7F);
    chk("t5_old_ok", 32'(ok_pulse), 32'd1);
    cyc(0, 0, 1, 1, 0, 7'h00);
    chk("t5_logout_wins", 32'(state), 32'd0);
    enter3(7'h15, 7'h2A, 7'h7F);
    prg();
    dig(7'h11);
    cyc(1, 0, 0, 1, 0, 7'h22);
    chk("t5_abort_wins", 32'(state), 32'd0);
    enter3(7'h15, 7'h2A, 7'h7F);
    chk("t5_still_ok", 32'(ok_pulse), 32'd1);
    lgo();
    dig(7'h15);
    dig(7'h2A);
    cyc(1, 1, 0, 0, 0, 7'h7F);
    chk("t5_digit_dropped", 32'(fail_pulse), 32'd1);
    dig(7'h15);
    dig(7'h2A);
    dig(7'h7F);
    cyc(1, 1, 0, 0, 0, 7'h55);
    chk("t5_submit_wins", 32'(ok_pulse), 32'd1);
    lgo();

    // T6: reset in the middle of a lockout restores everything.
    for (int k = 0; k < MAX_ERR; k++) begin
      dig(7'h01);
      sub();
    end
    chk("t6_lock", 32'(state), 32'd4);
    for (int i = 0; i < 279; i++) tck();
    chk("t6_cd321", 32'(cd_bcd), 32'h321);
    rst_n = 1'b0;
    idle();
    rst_n = 1'b1;
    chk("t6_state", 32'(state),   32'd0);
    chk("t6_cd",    32'(cd_bcd),  32'h000);
    chk("t6_err",   32'(err_cnt), 32'd0);
    enter3(7'h00, 7'h00, 7'h00);
    chk("t6_pwd_reset", 32'(ok_pulse), 32'd1);
    idle();

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
